road_sensor_conditioner: RTL and testbench

ROAD_SENSOR_CONDITIONER -- requirements
Module: road_sensor_conditioner

---
 rtl/road_sensor_conditioner.sv | 114 +++++++++++
 tb/tb_road_sensor_conditioner.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/road_sensor_conditioner.sv
// Vehicle-loop sensor conditioner: synchronizes and debounces the raw loop level,
// counts arrivals, and latches a service request toward the traffic light controller.
module road_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sensorRaw,
    input  logic [2:0] secondaryRoadLight_RYG,
    output logic       secondaryRoadSensor,
    output logic       sensorClean,
    output logic [7:0] vehicleCount
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // state     | meaning
    // IDLE      | no vehicle waiting
    // REQUEST   | vehicle seen, service requested until green is granted
    // SERVING   | secondary road is green
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVING = 2'd2
    } state_t;

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic [7:0]       count_q, count_d;
    state_t           state_q;
    logic             req_q;
    logic             green;

    assign green = (secondaryRoadLight_RYG == 3'b001);

    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        count_d = count_q;
        if (sync2_q == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            clean_d = sync2_q;
            if (sync2_q && (count_q != 8'hFF)) begin
                count_d = count_q + 8'd1;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            count_q <= 8'd0;
        end else begin
            sync1_q <= sensorRaw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            count_q <= count_d;
        end
    end

    // The request output is registered alongside the state so it equals (state == REQUEST).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clean_q && green) begin
                        state_q <= SERVING;
                        req_q   <= 1'b0;
                    end else if (clean_q) begin
                        state_q <= REQUEST;
                        req_q   <= 1'b1;
                    end
                end
                REQUEST: begin
                    if (green) begin
                        state_q <= SERVING;
                        req_q   <= 1'b0;
                    end
                end
                SERVING: begin
                    if (!green && clean_q) begin
                        state_q <= REQUEST;
                        req_q   <= 1'b1;
                    end else if (!green) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign secondaryRoadSensor = req_q;
    assign sensorClean         = clean_q;
    assign vehicleCount        = count_q;

endmodule

// File: tb/tb_road_sensor_conditioner.sv
// Directed self-checking bench for road_sensor_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_road_sensor_conditioner;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sensorRaw = 1'b0;
    logic [2:0] ryg = 3'b100;
    logic       req;
    logic       clean;
    logic [7:0] count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    road_sensor_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .sensorRaw              (sensorRaw),
        .secondaryRoadLight_RYG (ryg),
        .secondaryRoadSensor    (req),
        .sensorClean            (clean),
        .vehicleCount           (count)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic apply_reset(input logic raw);
        reset_n   = 1'b0;
        sensorRaw = raw;
        ryg       = 3'b100;
        step(2);
        reset_n   = 1'b1;
    endtask

    // Waits for the request to assert, bounded; a timeout counts as a failure.
    task automatic wait_req(input string name);
        int t;
        t = 0;
        while (req !== 1'b1 && t < 20) begin
            step(1);
            t++;
        end
        n_cmp++;
        if (req !== 1'b1) begin
            n_err++;
            $display("FAIL %s: request timeout, got %b expected 1", name, req);
        end
    endtask

    // Edge 0 is the first edge with reset_n=1; clean rises at edge 5, request at edge 6.
    task automatic test_reset();
        reset_n   = 1'b0;
        sensorRaw = 1'b1;
        ryg       = 3'b100;
        for (int i = 0; i < 2; i++) begin
            step(1);
            n_cmp++;
            if ({req, clean, count} !== 10'd0) begin
                n_err++;
                $display("FAIL reset_hold: got req=%b clean=%b cnt=%0d expected all 0", req, clean, count);
            end
        end
        reset_n = 1'b1;
        step(5);
        n_cmp++;
        if (clean !== 1'b0 || count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_early: got clean=%b cnt=%0d expected 0/0 at edge 4", clean, count);
        end
        step(1);
        n_cmp++;
        if (clean !== 1'b1 || count !== 8'd1 || req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_clean: got clean=%b cnt=%0d req=%b expected 1/1/0", clean, count, req);
        end
        step(1);
        n_cmp++;
        if (req !== 1'b1) begin
            n_err++;
            $display("FAIL reset_req: got %b expected 1", req);
        end
    endtask

    task automatic test_short_pulse();
        apply_reset(1'b0);
        step(3);
        sensorRaw = 1'b1;
        step(3);
        sensorRaw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            n_cmp++;
            if ({req, clean, count} !== 10'd0) begin
                n_err++;
                $display("FAIL short_pulse cyc %0d: got req=%b clean=%b cnt=%0d expected all 0", i, req, clean, count);
            end
        end
    endtask

    task automatic test_request_latch();
        apply_reset(1'b1);
        wait_req("latch_assert");
        sensorRaw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            n_cmp++;
            if (req !== 1'b1) begin
                n_err++;
                $display("FAIL latch_hold cyc %0d: got %b expected 1", i, req);
            end
        end
        n_cmp++;
        if (clean !== 1'b0) begin
            n_err++;
            $display("FAIL latch_clean_fell: got %b expected 0", clean);
        end
        ryg = 3'b001;
        step(1);
        n_cmp++;
        if (req !== 1'b0) begin
            n_err++;
            $display("FAIL latch_served: got %b expected 0", req);
        end
        ryg = 3'b100;
        for (int i = 0; i < 5; i++) begin
            step(1);
            n_cmp++;
            if (req !== 1'b0) begin
                n_err++;
                $display("FAIL latch_idle cyc %0d: got %b expected 0", i, req);
            end
        end
    endtask

    task automatic test_held_through_green();
        apply_reset(1'b1);
        wait_req("held_assert");
        ryg = 3'b011;
        for (int i = 0; i < 3; i++) begin
            step(1);
            n_cmp++;
            if (req !== 1'b1) begin
                n_err++;
                $display("FAIL invalid_ryg cyc %0d: got %b expected 1", i, req);
            end
        end
        ryg = 3'b001;
        step(1);
        n_cmp++;
        if (req !== 1'b0) begin
            n_err++;
            $display("FAIL held_green: got %b expected 0", req);
        end
        step(2);
        n_cmp++;
        if (req !== 1'b0) begin
            n_err++;
            $display("FAIL held_serving: got %b expected 0", req);
        end
        ryg = 3'b010;
        step(1);
        n_cmp++;
        if (req !== 1'b1) begin
            n_err++;
            $display("FAIL held_rerequest: got %b expected 1", req);
        end
    endtask

    // Clean rises 6 edges after a rise is driven, inside each 8-cycle high phase.
    task automatic test_saturation();
        logic [7:0] exp_cnt;
        apply_reset(1'b0);
        for (int p = 1; p <= 300; p++) begin
            sensorRaw = 1'b1;
            step(8);
            if (p == 1 || p == 254 || p == 255 || p == 256 || p == 300) begin
                exp_cnt = (p > 255) ? 8'd255 : 8'(p);
                n_cmp++;
                if (count !== exp_cnt) begin
                    n_err++;
                    $display("FAIL saturate pulse %0d: got %0d expected %0d", p, count, exp_cnt);
                end
            end
            sensorRaw = 1'b0;
            step(8);
        end
        step(10);
        n_cmp++;
        if (count !== 8'd255) begin
            n_err++;
            $display("FAIL saturate_hold: got %0d expected 255", count);
        end
    endtask

    task automatic test_reset_mid_request();
        apply_reset(1'b0);
        for (int p = 0; p < 7; p++) begin
            sensorRaw = 1'b1;
            step(8);
            sensorRaw = 1'b0;
            step(8);
        end
        n_cmp++;
        if (count !== 8'd7 || req !== 1'b1) begin
            n_err++;
            $display("FAIL mid_setup: got cnt=%0d req=%b expected 7/1", count, req);
        end
        sensorRaw = 1'b1;
        reset_n   = 1'b0;
        step(1);
        n_cmp++;
        if ({req, clean, count} !== 10'd0) begin
            n_err++;
            $display("FAIL mid_reset: got req=%b clean=%b cnt=%0d expected all 0", req, clean, count);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            n_cmp++;
            if ({req, clean, count} !== 10'd0) begin
                n_err++;
                $display("FAIL mid_redebounce edge %0d: got req=%b clean=%b cnt=%0d expected all 0", i, req, clean, count);
            end
        end
        step(1);
        n_cmp++;
        if (clean !== 1'b1 || count !== 8'd1 || req !== 1'b0) begin
            n_err++;
            $display("FAIL mid_clean: got clean=%b cnt=%0d req=%b expected 1/1/0", clean, count, req);
        end
        step(1);
        n_cmp++;
        if (req !== 1'b1) begin
            n_err++;
            $display("FAIL mid_rereq: got %b expected 1", req);
        end
    endtask

    initial begin
        test_reset();
        test_short_pulse();
        test_request_latch();
        test_held_through_green();
        test_saturation();
        test_reset_mid_request();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
